// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared op codes, state encoding and press decoding for the calculator sequencer
package calc_pkg;

   localparam logic [2:0]  OP_ADD   = 3'd0;
   localparam logic [2:0]  OP_SUB   = 3'd1;
   localparam logic [2:0]  OP_MUL   = 3'd2;
   localparam logic [2:0]  OP_DIV   = 3'd3;
   localparam logic [15:0] ERR_CODE = 16'hDEAD;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   typedef struct packed {
      logic       op_hit;
      logic [2:0] op;
      logic       clear;
   } press_t;

   // Pulses ordered {U, D, L, R, C}; only the highest-priority one survives.
   function automatic press_t resolve_press(input logic [4:0] p);
      press_t r;
      r = '0;
      if (p[4]) begin
         r.op_hit = 1'b1;
         r.op     = OP_ADD;
      end else if (p[3]) begin
         r.op_hit = 1'b1;
         r.op     = OP_SUB;
      end else if (p[2]) begin
         r.op_hit = 1'b1;
         r.op     = OP_MUL;
      end else if (p[1]) begin
         r.op_hit = 1'b1;
         r.op     = OP_DIV;
      end else if (p[0]) begin
         r.clear  = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer, stability counter and rising-edge press pulse for one button
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic CLK100MHZ,
   input  logic resetn,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK100MHZ or negedge resetn) begin
      if (!resetn) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         level_d <= level;
         press   <= level & ~level_d;
         // Any return to the accepted level restarts the stability window.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - button-driven operand/op sequencing and start/done handshake for the ALU
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int ALU_TIMEOUT     = 64
) (
   input  logic        CLK100MHZ,
   input  logic        resetn,
   input  logic [15:0] sw,
   input  logic        btnU,
   input  logic        btnD,
   input  logic        btnL,
   input  logic        btnR,
   input  logic        btnC,
   output logic [7:0]  A,
   output logic [7:0]  B,
   output logic [2:0]  op,
   output logic        alu_start,
   input  logic        alu_done,
   input  logic [15:0] alu_y,
   input  logic        alu_div0,
   output logic [15:0] result,
   output logic        result_valid,
   output logic        error,
   output logic [2:0]  state_dbg
);

   localparam int WW = $clog2(ALU_TIMEOUT + 1);
   localparam logic [WW-1:0] WD_LIMIT = WW'(ALU_TIMEOUT);

   logic [4:0] pulses;
   press_t     pr;

   state_t        state, state_n;
   logic [7:0]    a_n, b_n;
   logic [2:0]    op_n;
   logic [15:0]   result_n;
   logic [WW-1:0] wd, wd_n, wd_inc;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
      .CLK100MHZ(CLK100MHZ), .resetn(resetn), .btn_raw(btnU), .press(pulses[4]));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
      .CLK100MHZ(CLK100MHZ), .resetn(resetn), .btn_raw(btnD), .press(pulses[3]));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
      .CLK100MHZ(CLK100MHZ), .resetn(resetn), .btn_raw(btnL), .press(pulses[2]));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
      .CLK100MHZ(CLK100MHZ), .resetn(resetn), .btn_raw(btnR), .press(pulses[1]));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
      .CLK100MHZ(CLK100MHZ), .resetn(resetn), .btn_raw(btnC), .press(pulses[0]));

   assign pr     = resolve_press(pulses);
   assign wd_inc = wd + WW'(1);

   always_ff @(posedge CLK100MHZ or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         A      <= '0;
         B      <= '0;
         op     <= OP_ADD;
         result <= '0;
         wd     <= '0;
      end else begin
         state  <= state_n;
         A      <= a_n;
         B      <= b_n;
         op     <= op_n;
         result <= result_n;
         wd     <= wd_n;
      end
   end

   always_comb begin
      state_n  = state;
      a_n      = A;
      b_n      = B;
      op_n     = op;
      result_n = result;
      wd_n     = wd;
      case (state)
         ST_IDLE: begin
            if (pr.op_hit) begin
               a_n     = sw[7:0];
               b_n     = sw[15:8];
               op_n    = pr.op;
               state_n = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (pr.op_hit) begin
               op_n = pr.op;
            end else if (pr.clear) begin
               b_n     = sw[15:8];
               state_n = ST_START;
            end
         end
         ST_START: begin
            wd_n    = '0;
            state_n = ST_WAIT;
         end
         ST_WAIT: begin
            // A done in the last watchdog cycle still wins over the timeout.
            if (alu_done) begin
               result_n = alu_div0 ? ERR_CODE : alu_y;
               state_n  = alu_div0 ? ST_ERR : ST_DONE;
            end else if (wd_inc == WD_LIMIT) begin
               result_n = ERR_CODE;
               state_n  = ST_ERR;
            end else begin
               wd_n = wd_inc;
            end
         end
         ST_DONE: begin
            if (pr.op_hit) begin
               a_n     = result[7:0];
               b_n     = sw[15:8];
               op_n    = pr.op;
               state_n = ST_ARMED;
            end else if (pr.clear) begin
               state_n = ST_IDLE;
            end
         end
         ST_ERR: begin
            if (pr.clear) begin
               result_n = '0;
               state_n  = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign alu_start    = (state == ST_START);
   assign result_valid = (state == ST_DONE);
   assign error        = (state == ST_ERR);
   assign state_dbg    = state;

endmodule
